control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// Hardwired Moore control unit for a single-bus CPU: sequences fetch (T0-T2)
// and per-opcode execute steps (T3-T7), with halt/stop handling.
module control_unit (
  input  logic        i_clock,
  input  logic        i_clear,
  input  logic [31:0] i_ir,
  input  logic        i_con,
  input  logic        i_stop,
  output logic        o_run,
  output logic [4:0]  o_opcode,
  output logic        o_read,
  output logic        o_write,
  output logic        o_inc_pc,
  output logic        o_gra,
  output logic        o_grb,
  output logic        o_grc,
  output logic        o_rin,
  output logic        o_rout,
  output logic        o_ba_out,
  output logic        o_hi_in,
  output logic        o_lo_in,
  output logic        o_y_in,
  output logic        o_z_in,
  output logic        o_pc_in,
  output logic        o_ir_in,
  output logic        o_mar_in,
  output logic        o_mdr_in,
  output logic        o_inport_in,
  output logic        o_outport_in,
  output logic        o_con_in,
  output logic        o_hi_out,
  output logic        o_lo_out,
  output logic        o_y_out,
  output logic        o_zhigh_out,
  output logic        o_zlow_out,
  output logic        o_pc_out,
  output logic        o_mar_out,
  output logic        o_mdr_out,
  output logic        o_inport_out,
  output logic        o_outport_out,
  output logic        o_c_out
);

  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_T0    = 4'd1;
  localparam logic [3:0] S_T1    = 4'd2;
  localparam logic [3:0] S_T2    = 4'd3;
  localparam logic [3:0] S_T3    = 4'd4;
  localparam logic [3:0] S_T4    = 4'd5;
  localparam logic [3:0] S_T5    = 4'd6;
  localparam logic [3:0] S_T6    = 4'd7;
  localparam logic [3:0] S_T7    = 4'd8;
  localparam logic [3:0] S_HALT  = 4'd9;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_ANDI = 5'b01001;
  localparam logic [4:0] OP_ORI  = 5'b01010;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  typedef struct packed {
    logic read, write, inc_pc, gra, grb, grc, rin, rout, ba_out;
    logic hi_in, lo_in, y_in, z_in, pc_in, ir_in, mar_in, mdr_in;
    logic inport_in, outport_in, con_in;
    logic hi_out, lo_out, y_out, zhigh_out, zlow_out, pc_out, mar_out;
    logic mdr_out, inport_out, outport_out, c_out;
  } ctl_t;

  logic [3:0] r_state;
  logic       r_stop_pend;
  logic [3:0] w_next;
  logic [4:0] w_op;
  logic [4:0] w_alu_op;
  ctl_t       w_ctl;
  logic       w_unused_ir;

  assign w_unused_ir = ^i_ir[26:0];

  // Undefined opcodes are folded into nop so every later decode sees a legal op.
  always_comb begin
    case (i_ir[31:27])
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI,
      OP_ORI, OP_BR, OP_JR, OP_JAL, OP_IN, OP_OUT, OP_MFHI, OP_MFLO, OP_NOP,
      OP_HALT: w_op = i_ir[31:27];
      default: w_op = OP_NOP;
    endcase
  end

  // NOTE: non-blocking assignments here so every flop samples pre-edge values.
  always_ff @(posedge i_clock or negedge i_clear) begin
    if (!i_clear) begin
      r_state     <= S_RESET;
      r_stop_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_T0)
        r_stop_pend <= 1'b0;
      else if (i_stop)
        r_stop_pend <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET: w_next = S_T0;
      S_T0:    w_next = (i_stop || r_stop_pend) ? S_HALT : S_T1;
      S_T1:    w_next = S_T2;
      S_T2:    w_next = (w_op == OP_NOP) ? S_T0 : S_T3;
      S_T3: begin
        case (w_op)
          OP_HALT: w_next = S_HALT;
          OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: w_next = S_T0;
          default: w_next = S_T4;
        endcase
      end
      S_T4:    w_next = (w_op == OP_JAL) ? S_T0 : S_T5;
      S_T5:    w_next = (w_op == OP_LD || w_op == OP_ST || w_op == OP_BR) ? S_T6 : S_T0;
      S_T6:    w_next = (w_op == OP_BR) ? S_T0 : S_T7;
      S_T7:    w_next = S_T0;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_RESET;
    endcase
  end

  // NOTE: everything defaults to zero first so no path can infer a latch.
  always_comb begin
    w_ctl    = '0;
    w_alu_op = 5'b00000;
    case (r_state)
      S_T0: begin w_ctl.pc_out = 1'b1; w_ctl.mar_in = 1'b1; w_ctl.inc_pc = 1'b1; w_ctl.z_in = 1'b1; end
      S_T1: begin w_ctl.zlow_out = 1'b1; w_ctl.pc_in = 1'b1; w_ctl.read = 1'b1; w_ctl.mdr_in = 1'b1; end
      S_T2: begin w_ctl.mdr_out = 1'b1; w_ctl.ir_in = 1'b1; end
      S_T3: begin
        case (w_op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
            w_ctl.grb = 1'b1; w_ctl.rout = 1'b1; w_ctl.y_in = 1'b1;
          end
          OP_LDI, OP_LD, OP_ST: begin
            w_ctl.grb = 1'b1; w_ctl.ba_out = 1'b1; w_ctl.y_in = 1'b1;
          end
          OP_BR:   begin w_ctl.gra = 1'b1; w_ctl.rout = 1'b1; w_ctl.con_in = 1'b1; end
          OP_JAL:  begin w_ctl.grb = 1'b1; w_ctl.rin = 1'b1; w_ctl.pc_out = 1'b1; end
          OP_JR:   begin w_ctl.gra = 1'b1; w_ctl.rout = 1'b1; w_ctl.pc_in = 1'b1; end
          OP_IN:   begin w_ctl.inport_out = 1'b1; w_ctl.gra = 1'b1; w_ctl.rin = 1'b1; end
          OP_OUT:  begin w_ctl.gra = 1'b1; w_ctl.rout = 1'b1; w_ctl.outport_in = 1'b1; end
          OP_MFHI: begin w_ctl.hi_out = 1'b1; w_ctl.gra = 1'b1; w_ctl.rin = 1'b1; end
          OP_MFLO: begin w_ctl.lo_out = 1'b1; w_ctl.gra = 1'b1; w_ctl.rin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (w_op)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            w_ctl.grc = 1'b1; w_ctl.rout = 1'b1; w_ctl.z_in = 1'b1; w_alu_op = w_op;
          end
          OP_ADDI, OP_LDI, OP_LD, OP_ST: begin w_ctl.c_out = 1'b1; w_ctl.z_in = 1'b1; w_alu_op = OP_ADD; end
          OP_ANDI: begin w_ctl.c_out = 1'b1; w_ctl.z_in = 1'b1; w_alu_op = OP_AND; end
          OP_ORI:  begin w_ctl.c_out = 1'b1; w_ctl.z_in = 1'b1; w_alu_op = OP_OR; end
          OP_BR:   begin w_ctl.pc_out = 1'b1; w_ctl.y_in = 1'b1; end
          OP_JAL:  begin w_ctl.gra = 1'b1; w_ctl.rout = 1'b1; w_ctl.pc_in = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (w_op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin
            w_ctl.zlow_out = 1'b1; w_ctl.gra = 1'b1; w_ctl.rin = 1'b1;
          end
          OP_LD, OP_ST: begin w_ctl.zlow_out = 1'b1; w_ctl.mar_in = 1'b1; end
          OP_BR:   begin w_ctl.c_out = 1'b1; w_ctl.z_in = 1'b1; w_alu_op = OP_ADD; end
          default: ;
        endcase
      end
      S_T6: begin
        case (w_op)
          OP_LD: begin w_ctl.read = 1'b1; w_ctl.mdr_in = 1'b1; end
          OP_ST: begin w_ctl.gra = 1'b1; w_ctl.rout = 1'b1; w_ctl.mdr_in = 1'b1; end
          OP_BR: begin w_ctl.zlow_out = 1'b1; w_ctl.pc_in = i_con; end
          default: ;
        endcase
      end
      S_T7: begin
        case (w_op)
          OP_LD: begin w_ctl.mdr_out = 1'b1; w_ctl.gra = 1'b1; w_ctl.rin = 1'b1; end
          OP_ST: w_ctl.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign o_run         = (r_state != S_RESET) && (r_state != S_HALT);
  assign o_opcode      = w_alu_op;
  assign o_read        = w_ctl.read;
  assign o_write       = w_ctl.write;
  assign o_inc_pc      = w_ctl.inc_pc;
  assign o_gra         = w_ctl.gra;
  assign o_grb         = w_ctl.grb;
  assign o_grc         = w_ctl.grc;
  assign o_rin         = w_ctl.rin;
  assign o_rout        = w_ctl.rout;
  assign o_ba_out      = w_ctl.ba_out;
  assign o_hi_in       = w_ctl.hi_in;
  assign o_lo_in       = w_ctl.lo_in;
  assign o_y_in        = w_ctl.y_in;
  assign o_z_in        = w_ctl.z_in;
  assign o_pc_in       = w_ctl.pc_in;
  assign o_ir_in       = w_ctl.ir_in;
  assign o_mar_in      = w_ctl.mar_in;
  assign o_mdr_in      = w_ctl.mdr_in;
  assign o_inport_in   = w_ctl.inport_in;
  assign o_outport_in  = w_ctl.outport_in;
  assign o_con_in      = w_ctl.con_in;
  assign o_hi_out      = w_ctl.hi_out;
  assign o_lo_out      = w_ctl.lo_out;
  assign o_y_out       = w_ctl.y_out;
  assign o_zhigh_out   = w_ctl.zhigh_out;
  assign o_zlow_out    = w_ctl.zlow_out;
  assign o_pc_out      = w_ctl.pc_out;
  assign o_mar_out     = w_ctl.mar_out;
  assign o_mdr_out     = w_ctl.mdr_out;
  assign o_inport_out  = w_ctl.inport_out;
  assign o_outport_out = w_ctl.outport_out;
  assign o_c_out       = w_ctl.c_out;

endmodule
